// File: rtl/lampfpu_cmp_unpack_pipe.sv
// lampfpu_cmp_unpack_pipe: bf16 compare operand-prep stage with 2-entry skid buffer.
// Ports: clk, rst (async, high), flush_i; in_valid_i/in_ready_o + op_i/opA_i/opB_i in;
//        out_valid_o/out_ready_i + decoded do-flags, sign/exp/fract, class flags out.
// Option: define LAMP_CMP_DAZ_EN to flush subnormal operands to zero.
module lampfpu_cmp_unpack_pipe #(
  parameter int EXP_DW   = 8,
  parameter int FRACT_DW = 7,
  parameter int FLOAT_DW = 1 + EXP_DW + FRACT_DW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [1:0]          op_i,
  input  logic [FLOAT_DW-1:0] opA_i,
  input  logic [FLOAT_DW-1:0] opB_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic                doEq_o,
  output logic                doLt_o,
  output logic                doLe_o,
  output logic                opASign_o,
  output logic                opBSign_o,
  output logic [EXP_DW-1:0]   opAExp_o,
  output logic [EXP_DW-1:0]   opBExp_o,
  output logic [FRACT_DW-1:0] opAFract_o,
  output logic [FRACT_DW-1:0] opBFract_o,
  output logic                isAZer_o,
  output logic                isASNaN_o,
  output logic                isAQNaN_o,
  output logic                isBZer_o,
  output logic                isBSNaN_o,
  output logic                isBQNaN_o
);

  typedef struct packed {
    logic                sign;
    logic [EXP_DW-1:0]   ex;
    logic [FRACT_DW-1:0] fract;
    logic                zer;
    logic                snan;
    logic                qnan;
  } side_t;

  typedef struct packed {
    logic  do_eq;
    logic  do_lt;
    logic  do_le;
    side_t a;
    side_t b;
  } entry_t;

  function automatic side_t unpack_op(
    input logic [FLOAT_DW-1:0] v
  );
    side_t               s;
    logic [EXP_DW-1:0]   e;
    logic [FRACT_DW-1:0] f;
    logic                e_zero;
    logic                e_ones;
    logic                f_nz;
    e      = v[FLOAT_DW-2 -: EXP_DW];
    f      = v[FRACT_DW-1:0];
    e_zero = (e == '0);
    e_ones = &e;
    f_nz   = |f;
    s.sign  = v[FLOAT_DW-1];
    s.ex    = e;
    s.fract = f;
    s.snan  = e_ones && f_nz && !f[FRACT_DW-1];
    s.qnan  = e_ones && f[FRACT_DW-1];
`ifdef LAMP_CMP_DAZ_EN
    // Subnormals collapse to a signed zero.
    s.zer = e_zero;
    if (e_zero) s.fract = '0;
`else
    s.zer = e_zero && !f_nz;
`endif
    return s;
  endfunction

  entry_t     new_e;
  entry_t     head_q, head_d;
  entry_t     tail_q, tail_d;
  logic [1:0] cnt_q, cnt_d;
  logic       push;
  logic       pop;

  always_comb begin
    new_e       = '0;
    new_e.a     = unpack_op(opA_i);
    new_e.b     = unpack_op(opB_i);
    unique case (op_i)
      2'b00:   new_e.do_eq = 1'b1;
      2'b01:   new_e.do_lt = 1'b1;
      2'b10:   new_e.do_le = 1'b1;
      default: ;
    endcase
  end

  // Ready depends on stored occupancy only; low throughout reset.
  assign in_ready_o  = (cnt_q != 2'd2) && !rst;
  assign out_valid_o = (cnt_q != 2'd0);
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      cnt_d        = 2'd0;
      head_d.do_eq = 1'b0;
      head_d.do_lt = 1'b0;
      head_d.do_le = 1'b0;
      tail_d.do_eq = 1'b0;
      tail_d.do_lt = 1'b0;
      tail_d.do_le = 1'b0;
    end else if (push && !pop) begin
      cnt_d = cnt_q + 2'd1;
      if (cnt_q == 2'd0) head_d = new_e;
      else               tail_d = new_e;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 2'd1;
      if (cnt_q == 2'd2) head_d = tail_q;
    end else if (push && pop) begin
      // Only reachable with one entry: replace it.
      head_d = new_e;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign doEq_o     = head_q.do_eq;
  assign doLt_o     = head_q.do_lt;
  assign doLe_o     = head_q.do_le;
  assign opASign_o  = head_q.a.sign;
  assign opAExp_o   = head_q.a.ex;
  assign opAFract_o = head_q.a.fract;
  assign isAZer_o   = head_q.a.zer;
  assign isASNaN_o  = head_q.a.snan;
  assign isAQNaN_o  = head_q.a.qnan;
  assign opBSign_o  = head_q.b.sign;
  assign opBExp_o   = head_q.b.ex;
  assign opBFract_o = head_q.b.fract;
  assign isBZer_o   = head_q.b.zer;
  assign isBSNaN_o  = head_q.b.snan;
  assign isBQNaN_o  = head_q.b.qnan;

endmodule

// File: tb/tb_lampfpu_cmp_unpack_pipe.sv
// tb_lampfpu_cmp_unpack_pipe: self-checking bench for the bf16 compare prep stage.
// Table vectors, hand sequences and random traffic against a queue-based model.
module tb_lampfpu_cmp_unpack_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [1:0]  op;
  logic [15:0] a, b;
  logic        doEq, doLt, doLe, aSign, bSign;
  logic [7:0]  aExp, bExp;
  logic [6:0]  aFr, bFr;
  logic        aZ, aS, aQ, bZ, bS, bQ;

  int tests = 0;
  int fails = 0;
  logic [40:0] q[$];

  always #5 clk = ~clk;

  lampfpu_cmp_unpack_pipe dut (
    .clk(clk), .rst(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .op_i(op), .opA_i(a), .opB_i(b),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .doEq_o(doEq), .doLt_o(doLt), .doLe_o(doLe),
    .opASign_o(aSign), .opBSign_o(bSign),
    .opAExp_o(aExp), .opBExp_o(bExp),
    .opAFract_o(aFr), .opBFract_o(bFr),
    .isAZer_o(aZ), .isASNaN_o(aS), .isAQNaN_o(aQ),
    .isBZer_o(bZ), .isBSNaN_o(bS), .isBQNaN_o(bQ)
  );

`ifdef LAMP_CMP_DAZ_EN
  localparam bit DAZ = 1'b1;
`else
  localparam bit DAZ = 1'b0;
`endif

  // Reference: one operand's {sign, exp, fract, zero, snan, qnan}.
  function automatic logic [18:0] ref_side(input logic [15:0] v);
    int s, e, f;
    bit sub, zero, nan;
    s    = v / 32768;
    e    = (v / 128) % 256;
    f    = v % 128;
    sub  = (e == 0) && (f != 0);
    zero = (e == 0 && f == 0) || (DAZ && sub);
    nan  = (e == 255) && (f != 0);
    if (DAZ && sub) f = 0;
    return {s[0], e[7:0], f[6:0], zero, nan && f < 64, nan && f >= 64};
  endfunction

  function automatic logic [40:0] ref_entry(
    input logic [1:0] o, input logic [15:0] av, input logic [15:0] bv
  );
    return {o == 2'd0, o == 2'd1, o == 2'd2, ref_side(av), ref_side(bv)};
  endfunction

  function automatic logic [40:0] act_entry();
    return {doEq, doLt, doLe,
            aSign, aExp, aFr, aZ, aS, aQ,
            bSign, bExp, bFr, bZ, bS, bQ};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_model();
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    if (q.size() != 0) chk("head", 64'(act_entry()), 64'(q[0]));
  endtask

  // Drive one cycle of inputs, advance the model, check after the edge.
  task automatic apply(input bit fl, input bit v, input bit r,
                       input logic [1:0] o, input logic [15:0] av,
                       input logic [15:0] bv);
    bit psh, pp;
    flush = fl; in_valid = v; out_ready = r; op = o; a = av; b = bv;
    psh = v && (q.size() < 2);
    pp  = r && (q.size() != 0);
    if (fl) q.delete();
    else begin
      if (pp) void'(q.pop_front());
      if (psh) q.push_back(ref_entry(o, av, bv));
    end
    @(negedge clk);
    check_model();
  endtask

  function automatic logic [15:0] rnd_op();
    logic [15:0] sp[9] = '{16'h0000, 16'h8000, 16'h0001, 16'h8041,
                           16'h7F80, 16'hFF80, 16'h7FC0, 16'h7F81, 16'hFFFF};
    if ($urandom_range(0, 2) == 0) return sp[$urandom_range(0, 8)];
    return 16'($urandom);
  endfunction

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a, b;
    logic [2:0]  dos;
    logic [5:0]  cls;
    logic [6:0]  afr;
  } vec_t;

  vec_t vt[6];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{2'd1, 16'h3F80, 16'h4000, 3'b010, 6'b000_000, 7'h00};
    vt[1] = '{2'd0, 16'h7FC1, 16'hFF81, 3'b100, 6'b001_010, 7'h41};
    vt[2] = '{2'd2, 16'h8000, 16'h0000, 3'b001, 6'b100_100, 7'h00};
    vt[3] = '{2'd3, 16'h7F80, 16'h0000, 3'b000, 6'b000_100, 7'h00};
    if (DAZ)
      vt[4] = '{2'd0, 16'h0001, 16'h8000, 3'b100, 6'b100_100, 7'h00};
    else
      vt[4] = '{2'd0, 16'h0001, 16'h8000, 3'b100, 6'b000_100, 7'h01};
    vt[5] = '{2'd2, 16'hFF80, 16'h7FBF, 3'b001, 6'b000_010, 7'h00};

    rst = 1'b0; flush = 0; in_valid = 0; out_ready = 0;
    op = 0; a = 0; b = 0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_payload", 64'(act_entry()), 64'd0);
    rst = 1'b0;
    #1 chk("rel_ready", 64'(in_ready), 64'd1);

    // Single push, one-cycle latency.
    apply(0, 1, 0, 2'd1, 16'h3F80, 16'h4000);
    chk("lat_valid", 64'(out_valid), 64'd1);
    chk("lat_doLt", 64'({doEq, doLt, doLe}), 64'b010);
    chk("lat_exp", 64'({aExp, bExp}), 64'h7F80);
    apply(0, 0, 1, 0, 0, 0);

    // Table vectors.
    foreach (vt[i]) begin
      apply(0, 1, 1, vt[i].op, vt[i].a, vt[i].b);
      chk($sformatf("vec%0d_do", i), 64'({doEq, doLt, doLe}), 64'(vt[i].dos));
      chk($sformatf("vec%0d_cls", i), 64'({aZ, aS, aQ, bZ, bS, bQ}), 64'(vt[i].cls));
      chk($sformatf("vec%0d_afr", i), 64'(aFr), 64'(vt[i].afr));
    end
    apply(0, 0, 1, 0, 0, 0);

    // Backpressure: third push refused, then drain in order.
    apply(0, 1, 0, 2'd0, 16'h1111, 16'h2222);
    apply(0, 1, 0, 2'd1, 16'h3333, 16'h4444);
    chk("bp_ready", 64'(in_ready), 64'd0);
    apply(0, 1, 0, 2'd2, 16'h5555, 16'h6666);
    chk("bp_head_stable", 64'(aExp), 64'(8'h22));
    apply(0, 0, 1, 0, 0, 0);
    chk("bp_second", 64'({doEq, doLt, doLe}), 64'b010);
    apply(0, 0, 1, 0, 0, 0);
    chk("bp_empty", 64'(out_valid), 64'd0);

    // Streaming.
    for (int i = 0; i < 20; i++) begin
      apply(0, 1, 1, 2'($urandom_range(0, 3)), rnd_op(), rnd_op());
      chk("stream_ready", 64'(in_ready), 64'd1);
    end
    apply(0, 0, 1, 0, 0, 0);

    // Flush with full buffer and a simultaneous push.
    apply(0, 1, 0, 2'd0, 16'h3F80, 16'h3F80);
    apply(0, 1, 0, 2'd2, 16'h4000, 16'h4000);
    apply(1, 1, 1, 2'd1, 16'h1234, 16'h5678);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_do", 64'({doEq, doLt, doLe}), 64'd0);
    apply(0, 0, 1, 0, 0, 0);

    // Async reset mid-stream.
    apply(0, 1, 0, 2'd1, 16'hC000, 16'h4040);
    apply(0, 1, 0, 2'd2, 16'hC040, 16'h4080);
    #2 rst = 1'b1;
    #1;
    chk("arst_payload", 64'(act_entry()), 64'd0);
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_ready", 64'(in_ready), 64'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1 chk("arst_rel", 64'(in_ready), 64'd1);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      apply($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)),
            rnd_op(), rnd_op());

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lampfpu_cmp_unpack_pipe.md
Name: lampfpu_cmp_unpack_pipe

Overview:
- Registered operand-preparation stage directly upstream of the bf16 comparator.
- Accepts raw bf16 operand pairs plus a compare opcode over a valid/ready handshake.
- Decodes the opcode to one-hot do-flags, splits both operands into sign/exp/fract, and classifies zero/SNaN/QNaN.
- Presents the result to the combinational comparator from a 2-entry skid buffer, giving full throughput with registered outputs.

Parameters:
- EXP_DW, 8, exponent width (matches LAMP_FLOAT_E_DW).
- FRACT_DW, 7, fraction width (matches LAMP_FLOAT_F_DW).
- FLOAT_DW, 1+EXP_DW+FRACT_DW, packed operand width (16).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- flush_i  in  1  synchronous flush; empties the buffer.
- in_valid_i  in  1  upstream request valid.
- in_ready_o  out  1  buffer can accept a request.
- op_i  in  2  opcode: 00 EQ, 01 LT, 10 LE, 11 reserved.
- opA_i / opB_i  in  FLOAT_DW  packed bf16 operands: {sign, exp, fract}.
- out_valid_o  in/out: out  1  head entry valid.
- out_ready_i  in  1  consumer accepts the head entry.
- doEq_o / doLt_o / doLe_o  out  1 each  one-hot opcode decode.
- opASign_o / opBSign_o  out  1  operand signs.
- opAExp_o / opBExp_o  out  EXP_DW  operand exponents.
- opAFract_o / opBFract_o  out  FRACT_DW  operand fractions.
- isAZer_o, isASNaN_o, isAQNaN_o, isBZer_o, isBSNaN_o, isBQNaN_o  out  1 each  operand classification.

Behaviour:
- Classification (combinational at input, then registered):
  - zero = exp==0 && fract==0.
  - NaN = exp all-ones && fract!=0.
  - QNaN = NaN && fract[MSB]==1; SNaN = NaN && fract[MSB]==0.
  - Infinity is neither zero nor NaN.
- Opcode decode:
  - 00 → doEq=1; 01 → doLt=1; 10 → doLe=1.
  - 11 → all three low. The entry is still accepted and forwarded; the consumer sees isCmpValid=0.
- Storage:
  - 2-entry FIFO (head, tail) of decoded entries.
  - Occupancy counter cnt ∈ {0,1,2}.
  - Outputs always reflect the head entry.
- Handshakes:
  - in_ready_o = (cnt!=2), driven from registered state only; no combinational path from out_ready_i.
  - push = in_valid_i && in_ready_o.
  - pop = out_valid_o && out_ready_i.
  - out_valid_o = (cnt!=0).
- Counter/data updates:
  - push only: cnt+1; data written to head if cnt was 0, else to tail.
  - pop only: cnt-1; tail moves to head when cnt was 2.
  - push and pop at cnt=1: cnt stays 1; head ← new entry.
  - push and pop at cnt=2: cannot occur (in_ready_o=0).
  - No push or pop: state held.
- Latency and throughput:
  - Into an empty buffer: accepted at edge N, visible on outputs after edge N (one cycle).
  - Sustained throughput of 1 per cycle with out_ready_i held high.
- Stall: head payload and out_valid_o are stable while out_valid_o && !out_ready_i.
- Flush: flush_i=1 sets cnt←0 next edge and has priority over a simultaneous push and pop. Payload registers need not clear, but do-flags are cleared so the consumer reports no valid op.
- Reset: cnt=0, out_valid_o=0, in_ready_o=0 while rst is high and 1 after release. All payload outputs and do-flags are 0. Reset mid-transfer discards all entries.
- Fields are passed unmodified: no rounding or normalisation.

Optional Feature:
- Macro: LAMP_CMP_DAZ_EN.
- Defined:
  - Subnormal operands (exp==0, fract!=0) are treated as zero: isZer asserted and fract output forced to 0; sign is preserved.
  - Downstream therefore treats +sub and -0 as equal.
- Undefined:
  - Subnormals are passed raw with isZer=0.
  - They are ordered by fract against zero and each other.

Test Plan:
- Reset, then a single push: op=01, A=0x3F80, B=0x4000 → one cycle later out_valid=1, doLt=1; A exp=0x7F fract=0; B exp=0x80 fract=0; all class flags 0.
- Classification: A=0x7FC1, B=0xFF81 → isAQNaN=1, isBSNaN=1. Then A=0x8000, B=0x0000 → isAZer=isBZer=1. Then A=0x7F80 → no NaN flag set.
- Backpressure: out_ready=0, push three ops on consecutive cycles → first two accepted, in_ready=0 from the cycle after the second. Raise out_ready → entries emerge in order, no loss or duplication.
- Streaming: out_ready=1, 20 back-to-back pushes → 20 outputs on consecutive cycles, in_ready constantly 1.
- Flush/reset: flush with cnt=2 plus a simultaneous push → cnt=0, out_valid=0 next cycle, pushed entry dropped. Async rst pulse mid-stream → outputs zero immediately.
- DAZ: A=0x0001, B=0x8000, op=00. With LAMP_CMP_DAZ_EN → isAZer=1, opAFract=0. Without → isAZer=0, opAFract=0x01.
